// File: rtl/div_ctrl.sv
// Sequencer for RV64M divide/remainder ops on a shared unsigned multicycle divider.
// Conditions operands, short-circuits divide-by-zero and signed overflow, and fixes up signs.
module div_ctrl #(
  parameter int unsigned XLEN = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic              req_word,
  input  logic [XLEN-1:0]   req_a,
  input  logic [XLEN-1:0]   req_b,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_data,
  output logic              busy,
  output logic              div_valid,
  output logic [XLEN-1:0]   div_a,
  output logic [XLEN-1:0]   div_b,
  input  logic              div_done,
  input  logic [2*XLEN-1:0] div_c
);

  typedef enum logic [1:0] {StIdle, StBusy, StFlush, StResp} state_e;

  state_e          state_q, state_d;
  logic            rem_q, word_q, neg_quo_q, neg_rem_q;
  logic [XLEN-1:0] div_a_q, div_b_q, resp_data_q;

  logic            signed_op, sa, sb, b_zero, ovf, special, accept;
  logic [XLEN-1:0] a_ext, b_ext, mag_a, mag_b, min_neg;
  logic [XLEN-1:0] spec_q, spec_r, spec_res;
  logic [XLEN-1:0] quo, rem, quo_fix, rem_fix, norm_res;

  // Pick quotient or remainder; W forms always sign-extend the low word.
  function automatic logic [XLEN-1:0] select_res(input logic is_rem, input logic word,
                                                  input logic [XLEN-1:0] q,
                                                  input logic [XLEN-1:0] r);
    logic [XLEN-1:0] res;
    res = is_rem ? r : q;
    return word ? {{(XLEN-32){res[31]}}, res[31:0]} : res;
  endfunction

  always_comb begin
    signed_op = ~req_op[0];
    a_ext     = req_word ? {{(XLEN-32){signed_op & req_a[31]}}, req_a[31:0]} : req_a;
    b_ext     = req_word ? {{(XLEN-32){signed_op & req_b[31]}}, req_b[31:0]} : req_b;
    sa        = signed_op & a_ext[XLEN-1];
    sb        = signed_op & b_ext[XLEN-1];
    mag_a     = sa ? -a_ext : a_ext;
    mag_b     = sb ? -b_ext : b_ext;
    min_neg   = req_word ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
    b_zero    = (b_ext == '0);
    ovf       = signed_op & (a_ext == min_neg) & (b_ext == '1);
    special   = b_zero | ovf;
    spec_q    = b_zero ? '1 : a_ext;
    spec_r    = b_zero ? a_ext : '0;
    spec_res  = select_res(req_op[1], req_word, spec_q, spec_r);
  end

  always_comb begin
    quo      = div_c[XLEN-1:0];
    rem      = div_c[2*XLEN-1:XLEN];
    quo_fix  = neg_quo_q ? -quo : quo;
    rem_fix  = neg_rem_q ? -rem : rem;
    norm_res = select_res(rem_q, word_q, quo_fix, rem_fix);
  end

  assign req_ready = (state_q == StIdle) & ~flush;
  assign accept    = req_valid & req_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = special ? StResp : StBusy;
      // A flush coinciding with div_done has nothing left to wait for.
      StBusy:  if (flush) state_d = div_done ? StIdle : StFlush;
               else if (div_done) state_d = StResp;
      StFlush: if (div_done) state_d = StIdle;
      StResp:  if (flush || resp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      rem_q       <= 1'b0;
      word_q      <= 1'b0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      div_a_q     <= '0;
      div_b_q     <= '0;
      resp_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rem_q     <= req_op[1];
        word_q    <= req_word;
        neg_quo_q <= sa ^ sb;
        neg_rem_q <= sa;
        div_a_q   <= mag_a;
        div_b_q   <= mag_b;
        if (special) resp_data_q <= spec_res;
      end
      if (state_q == StBusy && div_done && !flush) resp_data_q <= norm_res;
    end
  end

  // A response being flushed is never presented as valid.
  assign resp_valid = (state_q == StResp) & ~flush;
  assign resp_data  = resp_data_q;
  assign busy       = (state_q != StIdle);
  assign div_valid  = (state_q == StBusy) | (state_q == StFlush);
  assign div_a      = div_a_q;
  assign div_b      = div_b_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl with a behavioural fixed-latency unsigned divider.
module tb_div_ctrl;

  logic         clk = 1'b0;
  logic         reset, flush, req_valid, req_ready, req_word;
  logic [1:0]   req_op;
  logic [63:0]  req_a, req_b, resp_data, div_a, div_b;
  logic         resp_valid, resp_ready, busy, div_valid, div_done;
  logic [127:0] div_c;

  int           n_checks = 0;
  int           n_fail = 0;
  int           lat = 3;
  logic [7:0]   cnt;
  logic [63:0]  seen_a, seen_b;

  always #5 clk = ~clk;

  div_ctrl #(.XLEN(64)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_word(req_word),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .busy(busy), .div_valid(div_valid), .div_a(div_a), .div_b(div_b),
    .div_done(div_done), .div_c(div_c)
  );

  // Divider model: done after lat+1 cycles of div_valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt <= '0;
    else if (div_valid && !div_done) cnt <= cnt + 8'd1;
    else cnt <= '0;
  end
  assign div_done = div_valid && (cnt == lat[7:0]);
  assign div_c    = (div_done && div_b != 64'd0) ? {div_a % div_b, div_a / div_b} : 128'd0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input string tag, input logic [1:0] op, input logic word,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp,
                       input int exp_cyc, input logic exp_div);
    int   cyc;
    logic used;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_word = word; req_a = a; req_b = b;
    check({tag, " req_ready"}, 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    cyc  = 1;
    used = div_valid;
    if (div_valid) begin
      seen_a = div_a;
      seen_b = div_b;
    end
    while (!resp_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
      used = used | div_valid;
    end
    check({tag, " resp_valid"}, 64'(resp_valid), 64'd1);
    check({tag, " latency"}, 64'(cyc), 64'(exp_cyc));
    check({tag, " data"}, resp_data, exp);
    check({tag, " div_used"}, 64'(used), 64'(exp_div));
    check({tag, " div_valid_at_resp"}, 64'(div_valid), 64'd0);
  endtask

  task automatic handshake(input string tag);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check({tag, " idle_after_hs"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int   n;
    logic bad_resp, bad_rdy, bad_dv;
    reset = 1'b1; flush = 1'b0; req_valid = 1'b0; req_op = 2'd0; req_word = 1'b0;
    req_a = '0; req_b = '0; resp_ready = 1'b0;
    seen_a = '0; seen_b = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst resp_valid", 64'(resp_valid), 64'd0);
    check("rst div_valid", 64'(div_valid), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst resp_data", resp_data, 64'd0);
    check("rst div_a", div_a, 64'd0);
    check("rst div_b", div_b, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post-rst req_ready", 64'(req_ready), 64'd1);

    // Normal path: latency lat+2 negedges after the accept edge.
    do_op("DIV -7/2", 2'd0, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 5, 1'b1);
    check("DIV div_a", seen_a, 64'd7);
    check("DIV div_b", seen_b, 64'd2);
    handshake("DIV");
    do_op("REM -7/2", 2'd2, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 5, 1'b1);
    handshake("REM");
    do_op("REMU 7/2", 2'd3, 1'b0, 64'd7, 64'd2, 64'd1, 5, 1'b1);
    handshake("REMU");

    // Special cases bypass the divider.
    do_op("DIVU 5/0", 2'd1, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1'b0);
    handshake("DIVU0");
    do_op("REM 5/0", 2'd2, 1'b0, 64'd5, 64'd0, 64'd5, 1, 1'b0);
    handshake("REM0");
    do_op("REMW /0", 2'd2, 1'b1, 64'h1_8000_0005, 64'h1_0000_0000,
          64'hFFFF_FFFF_8000_0005, 1, 1'b0);
    handshake("REMW0");
    do_op("DIV ovf", 2'd0, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
          64'h8000_0000_0000_0000, 1, 1'b0);
    handshake("DIVovf");
    do_op("REMW ovf", 2'd2, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 1, 1'b0);
    handshake("REMWovf");

    do_op("DIVUW", 2'd1, 1'b1, 64'h0000_0000_FFFF_FFFE, 64'd1,
          64'hFFFF_FFFF_FFFF_FFFE, 5, 1'b1);
    handshake("DIVUW");
    do_op("DIVW", 2'd0, 1'b1, 64'hAAAA_AAAA_0000_0010, 64'hFFFF_FFFF_FFFF_FFFE,
          64'hFFFF_FFFF_FFFF_FFF8, 5, 1'b1);

    // Consumer stalls for three cycles.
    for (int i = 0; i < 3; i++) begin
      check("hold resp_valid", 64'(resp_valid), 64'd1);
      check("hold resp_data", resp_data, 64'hFFFF_FFFF_FFFF_FFF8);
      check("hold req_ready", 64'(req_ready), 64'd0);
      check("hold busy", 64'(busy), 64'd1);
      @(negedge clk);
    end
    handshake("hold");
    check("hold resp_valid_after", 64'(resp_valid), 64'd0);
    check("hold req_ready_after", 64'(req_ready), 64'd1);

    // Flush in RESP drops the response even with resp_ready high.
    do_op("REMU 9/0", 2'd3, 1'b0, 64'd9, 64'd0, 64'd9, 1, 1'b0);
    flush = 1'b1; resp_ready = 1'b1;
    #1;
    check("resp flush resp_valid", 64'(resp_valid), 64'd0);
    @(negedge clk);
    flush = 1'b0; resp_ready = 1'b0;
    check("resp flush busy", 64'(busy), 64'd0);
    check("resp flush resp_valid_next", 64'(resp_valid), 64'd0);

    // Flush ten cycles into a long divide; hold a new request during FLUSH.
    lat = 15;
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd1; req_word = 1'b0; req_a = 64'd1000; req_b = 64'd10;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush busy", 64'(busy), 64'd1);
    check("flush div_valid", 64'(div_valid), 64'd1);
    req_valid = 1'b1; req_op = 2'd3; req_a = 64'd100; req_b = 64'd7;
    n = 0; bad_resp = 1'b0; bad_rdy = 1'b0; bad_dv = 1'b0;
    while (busy && n < 50) begin
      if (resp_valid) bad_resp = 1'b1;
      if (req_ready) bad_rdy = 1'b1;
      if (!div_valid) bad_dv = 1'b1;
      @(negedge clk);
      n++;
    end
    check("flush drained", 64'(busy), 64'd0);
    check("flush no resp", 64'(bad_resp), 64'd0);
    check("flush no ready", 64'(bad_rdy), 64'd0);
    check("flush div_valid held", 64'(bad_dv), 64'd0);
    check("flush resp_valid idle", 64'(resp_valid), 64'd0);
    check("flush req_ready idle", 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    while (!resp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("post-flush resp_valid", 64'(resp_valid), 64'd1);
    check("post-flush latency", 64'(n), 64'd17);
    check("post-flush data", resp_data, 64'd2);
    handshake("post-flush");

    // Asynchronous reset while busy.
    do begin
      @(negedge clk);
      req_valid = 1'b1; req_op = 2'd1; req_a = 64'd1000; req_b = 64'd10;
      @(negedge clk);
      req_valid = 1'b0;
    end while (0);
    repeat (3) @(negedge clk);
    check("pre-rst busy", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    check("arst busy", 64'(busy), 64'd0);
    check("arst div_valid", 64'(div_valid), 64'd0);
    check("arst resp_valid", 64'(resp_valid), 64'd0);
    check("arst resp_data", resp_data, 64'd0);
    check("arst div_a", div_a, 64'd0);
    check("arst div_b", div_b, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("arst req_ready", 64'(req_ready), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
